// File: rtl/adc_scan_sequencer.sv
// Command-driven ADC sequencer: SINGLE/SCAN/CONT over a conv req/ack handshake into a per-channel result bank.
// One ISSUE/WAIT/STORE/NEXT visit per channel; front-end stalls bounded by TIMEOUT; `ADC_SEQ_OVERSAMPLE_EN adds averaging.
module adc_scan_sequencer #(
    parameter int N_CH    = 8,
    parameter int CH_W    = 3,
    parameter int DATA_W  = 12,
    parameter int CMD_W   = 4,
    parameter int TIMEOUT = 1023
`ifdef ADC_SEQ_OVERSAMPLE_EN
    ,
    parameter int OS_LOG2 = 2
`endif
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [CMD_W-1:0]  cmd_i,
    input  logic              cmd_valid_i,
    input  logic [CH_W-1:0]   ch_sel_i,
    input  logic [N_CH-1:0]   ch_mask_i,
    output logic              conv_req_o,
    output logic [CH_W-1:0]   conv_ch_o,
    input  logic              conv_ack_i,
    input  logic [DATA_W-1:0] conv_data_i,
    input  logic [CH_W-1:0]   rd_ch_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [N_CH-1:0]   valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] CNT_MAX = TO_W'(TIMEOUT);

    localparam logic [CMD_W-1:0] CMD_SINGLE = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_SCAN   = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_CONT   = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_STOP   = CMD_W'(4);
    localparam logic [CMD_W-1:0] CMD_CLEAR  = CMD_W'(5);

`ifdef ADC_SEQ_OVERSAMPLE_EN
    localparam int ACC_W = DATA_W + OS_LOG2;
    localparam int OS_W  = (OS_LOG2 > 0) ? OS_LOG2 : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'((1 << OS_LOG2) - 1);
`else
    localparam int ACC_W = DATA_W;
`endif

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE, S_NEXT} state_t;
    typedef enum logic [1:0] {M_SINGLE, M_SCAN, M_CONT} mode_t;

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d;
    logic [N_CH-1:0]     mask_q, mask_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                stop_q, stop_d;
    logic [N_CH-1:0]     valid_q, valid_d;
    logic                err_q, err_d;
    logic                req_q, req_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   bank_q [N_CH];
    logic [DATA_W-1:0]   bank_d [N_CH];
`ifdef ADC_SEQ_OVERSAMPLE_EN
    logic [OS_W-1:0]     os_q, os_d;
`endif
    logic                nxt_found;
    logic [CH_W-1:0]     nxt_ptr;

    function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] m);
        lowest_set = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = CH_W'(i);
        end
    endfunction

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        stop_d  = stop_q;
        valid_d = valid_q;
        err_d   = err_q;
        bank_d  = bank_q;
        busy_d  = busy_q;
        req_d   = 1'b0;
        done_d  = 1'b0;
`ifdef ADC_SEQ_OVERSAMPLE_EN
        os_d    = os_q;
`endif

        // Lowest enabled channel strictly above the current pointer.
        nxt_found = 1'b0;
        nxt_ptr   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (CH_W'(i) > ptr_q)) begin
                nxt_found = 1'b1;
                nxt_ptr   = CH_W'(i);
            end
        end

        if (cmd_valid_i && (cmd_i == CMD_CLEAR)) begin
            valid_d = '0;
            err_d   = 1'b0;
        end
        if (cmd_valid_i && (cmd_i == CMD_STOP) && (state_q != S_IDLE)) stop_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
`ifdef ADC_SEQ_OVERSAMPLE_EN
                os_d   = '0;
`endif
                if (cmd_valid_i && (cmd_i == CMD_SINGLE)) begin
                    if (int'(ch_sel_i) < N_CH) begin
                        mode_d  = M_SINGLE;
                        ptr_d   = ch_sel_i;
                        state_d = S_ISSUE;
                        req_d   = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cmd_valid_i && ((cmd_i == CMD_SCAN) || (cmd_i == CMD_CONT))) begin
                    if (|ch_mask_i) begin
                        mode_d  = (cmd_i == CMD_SCAN) ? M_SCAN : M_CONT;
                        mask_d  = ch_mask_i;
                        ptr_d   = lowest_set(ch_mask_i);
                        state_d = S_ISSUE;
                        req_d   = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // An ack on the timeout cycle still counts as a good conversion.
                if (conv_ack_i) begin
`ifdef ADC_SEQ_OVERSAMPLE_EN
                    acc_d = ((os_q == '0) ? '0 : acc_q) + ACC_W'(conv_data_i);
                    if (os_q == OS_LAST) begin
                        state_d = S_STORE;
                    end else begin
                        os_d    = os_q + OS_W'(1);
                        state_d = S_ISSUE;
                        req_d   = 1'b1;
                    end
`else
                    acc_d   = conv_data_i;
                    state_d = S_STORE;
`endif
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_STORE: begin
`ifdef ADC_SEQ_OVERSAMPLE_EN
                bank_d[ptr_q] = DATA_W'(acc_q >> OS_LOG2);
`else
                bank_d[ptr_q] = acc_q;
`endif
                valid_d[ptr_q] = 1'b1;
                state_d        = S_NEXT;
            end
            S_NEXT: begin
`ifdef ADC_SEQ_OVERSAMPLE_EN
                os_d = '0;
`endif
                if (stop_d) begin
                    stop_d  = 1'b0;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (mode_q == M_SINGLE) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (nxt_found) begin
                    ptr_d   = nxt_ptr;
                    state_d = S_ISSUE;
                    req_d   = 1'b1;
                end else begin
                    done_d = 1'b1;
                    if (mode_q == M_CONT) begin
                        ptr_d   = lowest_set(mask_q);
                        state_d = S_ISSUE;
                        req_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= S_IDLE;
            mode_q  <= M_SINGLE;
            mask_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            stop_q  <= 1'b0;
            valid_q <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < N_CH; i++) bank_q[i] <= '0;
`ifdef ADC_SEQ_OVERSAMPLE_EN
            os_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            stop_q  <= stop_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            req_q   <= req_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            bank_q  <= bank_d;
`ifdef ADC_SEQ_OVERSAMPLE_EN
            os_q    <= os_d;
`endif
        end
    end

    assign conv_req_o = req_q;
    assign conv_ch_o  = ptr_q;
    assign valid_o    = valid_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign rd_data_o  = (int'(rd_ch_i) < N_CH) ? bank_q[rd_ch_i] : '0;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Randomised bench for adc_scan_sequencer: request scoreboard plus a per-channel result model.
module tb_adc_scan_sequencer;
    localparam int N_CH = 8, CH_W = 3, DATA_W = 12, CMD_W = 4, TIMEOUT = 15;
    localparam int C_SINGLE = 1, C_SCAN = 2, C_CONT = 3, C_STOP = 4, C_CLEAR = 5;

    logic              clk_clk = 1'b0;
    logic              reset_reset = 1'b1;
    logic [CMD_W-1:0]  cmd_i;
    logic              cmd_valid_i;
    logic [CH_W-1:0]   ch_sel_i;
    logic [N_CH-1:0]   ch_mask_i;
    logic              conv_req_o;
    logic [CH_W-1:0]   conv_ch_o;
    logic              conv_ack_i;
    logic [DATA_W-1:0] conv_data_i;
    logic [CH_W-1:0]   rd_ch_i;
    logic [DATA_W-1:0] rd_data_o;
    logic [N_CH-1:0]   valid_o;
    logic              busy_o, done_o, err_o;

    adc_scan_sequencer #(.N_CH(N_CH), .CH_W(CH_W), .DATA_W(DATA_W), .CMD_W(CMD_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .cmd_i(cmd_i), .cmd_valid_i(cmd_valid_i),
        .ch_sel_i(ch_sel_i), .ch_mask_i(ch_mask_i), .conv_req_o(conv_req_o), .conv_ch_o(conv_ch_o),
        .conv_ack_i(conv_ack_i), .conv_data_i(conv_data_i), .rd_ch_i(rd_ch_i), .rd_data_o(rd_data_o),
        .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        int                dly;
        logic [DATA_W-1:0] dat;
    } plan_t;

    plan_t             plan_q[$];
    int                exp_ch_q[$];
    plan_t             rsp_p;
    logic [DATA_W-1:0] m_bank [N_CH];
    logic [N_CH-1:0]   m_valid;
    logic              m_err;
    int                done_seen, done_exp, req_seen;
    int                checks, errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a visit whose ack arrives within TIMEOUT+1 wait cycles stores data, otherwise flags an error.
    task automatic plan_visit(input int ch, input int dly, input logic [DATA_W-1:0] d);
        plan_t p;
        p.dly = dly;
        p.dat = d;
        plan_q.push_back(p);
        exp_ch_q.push_back(ch);
        if (dly <= TIMEOUT + 1) begin
            m_bank[ch]  = d;
            m_valid[ch] = 1'b1;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic plan_scan(input logic [N_CH-1:0] m, input bit add_done, input int fixed_dly);
        for (int i = 0; i < N_CH; i++) begin
            if (m[i]) begin
                int d;
                d = (fixed_dly > 0) ? fixed_dly :
                    (($urandom_range(0, 5) == 0) ? TIMEOUT + 2 : int'($urandom_range(1, 6)));
                plan_visit(i, d, DATA_W'($urandom));
            end
        end
        if (add_done) done_exp++;
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the strobe.
    task automatic send(input int c, input int ch, input logic [N_CH-1:0] m);
        cmd_i       = CMD_W'(c);
        ch_sel_i    = CH_W'(ch);
        ch_mask_i   = m;
        cmd_valid_i = 1'b1;
        @(negedge clk_clk);
        cmd_valid_i = 1'b0;
        cmd_i       = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_o && n < 600) begin
            @(negedge clk_clk);
            n++;
        end
        if (busy_o) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout: busy_o still 1 after %0d cycles, required 0", name, n);
        end
        repeat (3) @(negedge clk_clk);
    endtask

    task automatic verify(input string tag);
        for (int i = 0; i < N_CH; i++) begin
            rd_ch_i = CH_W'(i);
            #1;
            check($sformatf("%s_rd%0d", tag, i), 32'(rd_data_o), 32'(m_bank[i]));
        end
        check({tag, "_valid"}, 32'(valid_o), 32'(m_valid));
        check({tag, "_err"}, 32'(err_o), 32'(m_err));
        check({tag, "_done_cnt"}, 32'(done_seen), 32'(done_exp));
        check({tag, "_missing_reqs"}, 32'(exp_ch_q.size()), 32'd0);
        @(negedge clk_clk);
    endtask

    // Monitor: every request is popped against the expected channel order.
    initial begin
        forever begin
            @(negedge clk_clk);
            if (!reset_reset) begin
                if (conv_req_o) begin
                    req_seen++;
                    if (exp_ch_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got request on ch %0d, required none", conv_ch_o);
                    end else begin
                        check("req_ch", 32'(conv_ch_o), 32'(exp_ch_q.pop_front()));
                    end
                end
                if (done_o) done_seen++;
            end
        end
    end

    // Front-end responder: ack arrives dly cycles after the request cycle, or never on a planned timeout.
    initial begin
        conv_ack_i  = 1'b0;
        conv_data_i = '0;
        forever begin
            @(negedge clk_clk);
            if (!reset_reset && conv_req_o && plan_q.size() > 0) begin
                rsp_p = plan_q.pop_front();
                if (rsp_p.dly <= TIMEOUT + 1) begin
                    repeat (rsp_p.dly) @(negedge clk_clk);
                    conv_ack_i  = 1'b1;
                    conv_data_i = rsp_p.dat;
                    @(negedge clk_clk);
                    conv_ack_i  = 1'b0;
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, base;
        logic [N_CH-1:0] m;
        cmd_i = '0; cmd_valid_i = 1'b0; ch_sel_i = '0; ch_mask_i = '0; rd_ch_i = '0;
        for (int i = 0; i < N_CH; i++) m_bank[i] = '0;
        m_valid = '0; m_err = 1'b0;
        done_seen = 0; done_exp = 0; req_seen = 0; checks = 0; errors = 0;

        repeat (3) @(negedge clk_clk);
        check("rst_req", 32'(conv_req_o), 0);
        check("rst_ch", 32'(conv_ch_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_rd", 32'(rd_data_o), 0);
        reset_reset = 1'b0;
        repeat (2) @(negedge clk_clk);

        // SINGLE ch5, ack 3 cycles after request
        plan_visit(5, 3, 12'hABC);
        done_exp++;
        send(C_SINGLE, 5, '0);
        check("single_busy_rise", 32'(busy_o), 1);
        check("single_req_now", 32'(conv_req_o), 1);
        wait_idle("single");
        verify("single");

        // SCAN 1010_0101 with immediate acks, data = ch*0x100
        for (int i = 0; i < N_CH; i++)
            if (i == 0 || i == 2 || i == 5 || i == 7) plan_visit(i, 1, DATA_W'(i * 'h100));
        done_exp++;
        send(C_SCAN, 0, 8'b1010_0101);
        wait_idle("scan_a5");
        verify("scan_a5");

        // random scans, some with timeouts; extra commands while busy must be dropped
        for (int it = 0; it < 6; it++) begin
            m = N_CH'($urandom_range(1, (1 << N_CH) - 1));
            plan_scan(m, 1'b1, 0);
            send(C_SCAN, 0, m);
            if (it[0] && busy_o) begin
                send(C_SINGLE, $urandom_range(0, N_CH - 1), '0);
                send(C_CONT, 0, '1);
            end
            wait_idle("rand_scan");
            verify($sformatf("rand_scan%0d", it));
        end

        send(C_CLEAR, 0, '0);
        m_valid = '0; m_err = 1'b0;
        verify("clear1");

        // SINGLE ch2 with no ack: err after TIMEOUT+1 wait cycles
        plan_visit(2, TIMEOUT + 2, '0);
        done_exp++;
        send(C_SINGLE, 2, '0);
        n = 0;
        while (!conv_req_o && n < 10) begin @(negedge clk_clk); n++; end
        k = 0;
        while (!err_o && k < 60) begin @(negedge clk_clk); k++; end
        check("timeout_latency", 32'(k), 32'(TIMEOUT + 2));
        wait_idle("timeout");
        verify("timeout");
        send(C_CLEAR, 0, '0);
        m_valid = '0; m_err = 1'b0;
        check("clear_err_next", 32'(err_o), 0);
        verify("clear2");

        // ack on the timeout cycle wins
        plan_visit(3, TIMEOUT + 1, 12'h5A5);
        done_exp++;
        send(C_SINGLE, 3, '0);
        wait_idle("collide");
        verify("collide");

        // empty mask SCAN: immediate done, never busy
        done_exp++;
        send(C_SCAN, 0, '0);
        check("empty_done", 32'(done_o), 1);
        check("empty_busy", 32'(busy_o), 0);
        repeat (2) @(negedge clk_clk);

        // STOP while idle is a no-op
        send(C_STOP, 0, '0);
        check("stop_idle_busy", 32'(busy_o), 0);
        repeat (3) @(negedge clk_clk);
        verify("stop_idle");

        // CONT on 0000_0011: 3 full passes, STOP during WAIT of ch1 in the 4th
        for (int p = 0; p < 4; p++)
            for (int ch = 0; ch < 2; ch++)
                plan_visit(ch, (p == 3 && ch == 1) ? 12 : int'($urandom_range(1, 3)), DATA_W'($urandom));
        done_exp += 3;
        base = req_seen;
        send(C_CONT, 0, 8'b0000_0011);
        n = 0;
        while (req_seen < base + 8 && n < 400) begin @(negedge clk_clk); n++; end
        check("cont_reached_8th_req", 32'(req_seen - base >= 8), 1);
        repeat (2) @(negedge clk_clk);
        send(C_STOP, 0, '0);
        wait_idle("cont");
        repeat (10) @(negedge clk_clk);
        verify("cont_stop");

        // reset mid-SCAN while a request is on the wire
        plan_scan('1, 1'b0, 5);
        base = req_seen;
        send(C_SCAN, 0, '1);
        n = 0;
        while (!(conv_req_o && (req_seen - base) >= 2) && n < 200) begin @(negedge clk_clk); n++; end
        #1 reset_reset = 1'b1;
        #1;
        check("midrst_req", 32'(conv_req_o), 0);
        check("midrst_busy", 32'(busy_o), 0);
        check("midrst_valid", 32'(valid_o), 0);
        check("midrst_err", 32'(err_o), 0);
        check("midrst_done", 32'(done_o), 0);
        rd_ch_i = '0;
        #1 check("midrst_rd0", 32'(rd_data_o), 0);
        exp_ch_q.delete();
        plan_q.delete();
        for (int i = 0; i < N_CH; i++) m_bank[i] = '0;
        m_valid = '0; m_err = 1'b0;
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        repeat (20) @(negedge clk_clk);
        verify("post_reset");

        m = N_CH'($urandom_range(1, (1 << N_CH) - 1));
        plan_scan(m, 1'b1, 0);
        send(C_SCAN, 0, m);
        wait_idle("after_reset_scan");
        verify("after_reset_scan");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
